// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port between a core and a
// word-wide synchronous memory.
//   req_*  : core request (valid/ready), RV32I funct3 width/sign code
//   resp_* : core response (valid/ready), formatted load data and error flag
//   mem_*  : word address, registered one-cycle ld/str strobes, byte enables,
//            lane-positioned store data; mem_rdata arrives the cycle after
//            mem_ld is sampled
// Flow: IDLE -> RESP (error), IDLE -> ACCESS -> RESP (store),
//       IDLE -> ACCESS -> WAIT -> RESP (load).
module lsu_mem_port #(
  parameter int ADDWIDTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [ADDWIDTH-1:0] mem_addr,
  output logic                mem_ld,
  output logic                mem_str,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        req_err;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [31:0] lane;
  logic [31:0] ld_data;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // Request legality, evaluated on the raw request in IDLE.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = |req_addr[1:0];
      default:        req_err = 1'b1;
    endcase
    // Unsigned widths have no store form.
    if (req_we && req_funct3[2]) req_err = 1'b1;
    if ((req_addr >> (ADDWIDTH + 2)) != 32'd0) req_err = 1'b1;
  end

  // Store lane placement: replicate so the enabled lanes carry the data
  // regardless of offset.
  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        st_be = 4'b0001 << req_addr[1:0];
        st_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be = 4'b0011 << req_addr[1:0];
        st_wd = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be = 4'b1111;
        st_wd = req_wdata;
      end
    endcase
  end

  // Load formatting: shift the addressed lane down, then extend.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'd0, lane[7:0]};
      3'b101:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_ld     <= 1'b0;
      mem_str    <= 1'b0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            off_q      <= req_addr[1:0];
            resp_rdata <= 32'd0;
            if (req_err) begin
              resp_err <= 1'b1;
              state    <= S_RESP;
            end else begin
              state    <= S_ACCESS;
              mem_addr <= req_addr[ADDWIDTH+1:2];
              mem_ld   <= ~req_we;
              mem_str  <= req_we;
              if (req_we) begin
                mem_be    <= st_be;
                mem_wdata <= st_wd;
              end
            end
          end
        end
        S_ACCESS: begin
          mem_ld    <= 1'b0;
          mem_str   <= 1'b0;
          mem_be    <= 4'd0;
          mem_wdata <= 32'd0;
          if (we_q) begin
            mem_addr <= '0;
            state    <= S_RESP;
          end else begin
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          resp_rdata <= ld_data;
          mem_addr   <= '0;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have parameter ADDWIDTH, default 12, giving the width of the memory word address.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit, core request present.
REQ-005 SHALL have port req_ready, output, 1 bit, request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits, RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, 32 bits, the byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit, response present.
REQ-011 SHALL have port resp_ready, input, 1 bit, core consumes the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits, the formatted load result (0 for stores and errors).
REQ-013 SHALL have port resp_err, output, 1 bit, misaligned, out-of-range or illegal request.
REQ-014 SHALL have port mem_addr, output, ADDWIDTH bits, the memory word address.
REQ-015 SHALL have port mem_ld, output, 1 bit, memory read strobe.
REQ-016 SHALL have port mem_str, output, 1 bit, memory write strobe.
REQ-017 SHALL have port mem_be, output, 4 bits, byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-018 SHALL have port mem_wdata, output, 32 bits, lane-positioned store data.
REQ-019 SHALL have port mem_rdata, input, 32 bits, memory read data, valid the cycle after mem_ld is sampled.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, WAIT and RESP; req_ready SHALL equal (state==IDLE).
REQ-021 SHALL, on acceptance in IDLE, latch we, funct3, addr[1:0] and the word address req_addr[ADDWIDTH+1:2].
REQ-022 SHALL flag an error on acceptance for any of: funct3 not in {000, 001, 010, 100, 101}; a store with funct3 100 or 101; H/HU with addr[0]=1; W with addr[1:0]!=00; req_addr[31:ADDWIDTH+2] nonzero.
REQ-023 SHALL, on an erroneous request, go IDLE->RESP with resp_err=1 and resp_rdata=0, with no memory strobe ever asserted.
REQ-024 SHALL otherwise go IDLE->ACCESS; mem_ld/mem_str SHALL be registered and high only in ACCESS, for exactly one cycle.
REQ-025 SHALL, for a store, generate mem_be as B: 0001<<off, H: 0011<<off, W: 1111, and set mem_wdata to the byte replicated x4 (B), the halfword replicated x2 (H) or the full word (W); ACCESS->RESP.
REQ-026 SHALL, for a load, hold mem_be=0000; ACCESS->WAIT; in WAIT, select the lane by off, sign-extend (B/H) or zero-extend (BU/HU), register the result into resp_rdata, and go WAIT->RESP.
REQ-027 SHALL hold resp_valid=1 and resp_rdata/resp_err stable in RESP until resp_ready=1, then go to IDLE; no new request is accepted in that same cycle.
REQ-028 SHALL give latency from the accept edge to resp_valid of 1 cycle for an error, 2 cycles for a store and 3 cycles for a load, when resp_ready is held high.
REQ-029 SHALL hold mem_addr at the latched word address from ACCESS through WAIT, and at 0 in IDLE.
REQ-030 SHALL ignore req_valid and all req_* inputs outside IDLE.

Reset
REQ-031 SHALL, while rst=1, immediately force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_ld=0, mem_str=0, mem_be=0, mem_addr=0 and mem_wdata=0.
REQ-032 SHALL, on reset mid-operation (ACCESS or WAIT), drop any pending strobe and response; no response is ever produced for that request.

Verification
REQ-033 SHALL cover: SW addr 0x10, wdata 0xDEADBEEF -> one cycle of mem_str, mem_addr=4, be=1111, wdata=0xDEADBEEF; resp after 2 cycles, err=0.
REQ-034 SHALL cover: SB addr 0x13, wdata 0xA5 -> be=1000, wdata=0xA5A5A5A5, mem_addr=4.
REQ-035 SHALL cover: LB addr 0x12 with mem_rdata 0x0080FF00 -> resp_rdata=0xFFFFFF80; the same case with LBU -> 0x00000080; resp 3 cycles after accept.
REQ-036 SHALL cover: LW addr 0x06 -> resp_err=1 after 1 cycle, mem_ld never asserted; LH addr 0x4001 (ADDWIDTH=12) -> err.
REQ-037 SHALL cover: resp_ready held low 5 cycles -> resp_valid and data stable and req_ready=0 throughout.
REQ-038 SHALL cover: rst asserted in the WAIT state of a load -> all outputs at reset values asynchronously and no resp_valid afterwards.
